clk_mode_ctrl: RTL and testbench
================================

CLK_MODE_CTRL -- requirements
Module: clk_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, number of clk_div instances sequenced (legal 2..8); MW = $clog2(NUM_MODES).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, cycles all divider enables are held low before a switch (>=1).
REQ-003 SHALL have parameter WARM_CYC, default 8, cycles a newly enabled divider runs before the output gate opens (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  mode-change request present.
REQ-007 SHALL have port req_mode  input  MW  requested mode index.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-009 SHALL have port div_en  output  NUM_MODES  one-hot or all-zero enable, one bit per divider instance.
REQ-010 SHALL have port sel  output  MW  select for the downstream output mux.
REQ-011 SHALL have port gate_en  output  1  output clock gate enable; high only when the selected divider is warmed up.
REQ-012 SHALL have port mode_cur  output  MW  currently committed mode.
REQ-013 SHALL have port err  output  1  sticky illegal-request flag (present only with MODE_CTRL_ERR_EN).

Function
REQ-014 SHALL implement FSM states IDLE, DRAIN, WARM; req_ready SHALL equal (state==IDLE).
REQ-015 SHALL accept a request on a posedge where req_valid & req_ready.
REQ-016 SHALL, when the accepted req_mode equals mode_cur, stay in IDLE with all outputs unchanged.
REQ-017 SHALL, when the accepted req_mode is legal and differs from mode_cur, register gate_en<=0, div_en<=0, load the timer with SETTLE_CYC and enter DRAIN.
REQ-018 SHALL, on the SETTLE_CYC-th edge in DRAIN, register sel<=new mode, mode_cur<=new mode, div_en<=onehot(new mode), load the timer with WARM_CYC and enter WARM.
REQ-019 SHALL, on the WARM_CYC-th edge in WARM, register gate_en<=1 and enter IDLE; accept-edge to gate_en high SHALL be exactly SETTLE_CYC+WARM_CYC edges.
REQ-020 SHALL hold req_mode of the accepted request internally; req_mode changes after acceptance SHALL have no effect.
REQ-021 SHALL ignore req_valid outside IDLE (no queuing); the requester must hold req_valid until accepted.
REQ-022 SHALL treat req_mode >= NUM_MODES as illegal: accepted (req_ready high), no state change.
REQ-023 SHALL never assert gate_en while div_en is zero or while sel differs from mode_cur.
REQ-024 SHALL, when a request is accepted in the same cycle as the internal timer reaches zero, accept it only if state==IDLE at that edge (no same-edge re-entry from WARM).

Reset
REQ-025 SHALL on rstn low immediately force state=WARM, timer=WARM_CYC, mode_cur=0, sel=0, div_en=1 (mode 0), gate_en=0, err=0.
REQ-026 SHALL, after rstn deasserts, raise gate_en exactly WARM_CYC edges later and enter IDLE.
REQ-027 SHALL abandon any in-progress switch on reset mid-operation with no glitch on gate_en (gate_en goes and stays low).

Configuration
REQ-028 SHALL, with MODE_CTRL_ERR_EN defined, provide port err, set to 1 on the edge accepting an illegal request and cleared only by reset.
REQ-029 SHALL, without MODE_CTRL_ERR_EN, omit port err and silently drop illegal requests; all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum and default SETTLE_CYC/WARM_CYC constants in shared package clk_mode_pkg.
REQ-031 SHALL implement the reload down-counter as sub-module clk_mode_timer (load, value, done pulse).

Verification
REQ-032 SHALL cover reset release: rstn 0->1 -> div_en=0001, sel=0, gate_en rises after exactly 8 edges, req_ready high thereafter.
REQ-033 SHALL cover switch 0->2: accept req_mode=2 -> div_en=0000 for 4 cycles, then div_en=0100, sel=2, mode_cur=2; gate_en high 12 edges after accept.
REQ-034 SHALL cover same-mode request: req_mode=mode_cur=1 -> accepted, gate_en stays 1, div_en unchanged.
REQ-035 SHALL cover back-to-back requests: req_valid held with req_mode=3 during a 0->1 switch -> ignored until IDLE, then accepted; final mode_cur=3.
REQ-036 SHALL cover an illegal request with NUM_MODES=3: req_mode=3 -> no state change; err=1 (macro defined) / no err port (undefined).
REQ-037 SHALL cover reset mid-DRAIN: rstn low 2 cycles into a switch -> outputs at reset values, gate_en never pulses.

Source files
------------

// File: rtl/clk_mode_pkg.sv
// rtl/clk_mode_pkg.sv - shared state encoding and timing defaults for clk_mode_ctrl
package clk_mode_pkg;

  // FSM states of the divider mode sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WARM  = 2'd2
  } state_e;

  localparam int SETTLE_CYC_DEF = 4;
  localparam int WARM_CYC_DEF   = 8;

  // Width needed to hold the larger of the two reload values
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_mode_timer.sv
// rtl/clk_mode_timer.sv - reloadable down-counter with a done pulse on its last count
module clk_mode_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] value_q;
  logic [TW-1:0] value_d;

  // Reload takes priority; otherwise count down and park at zero
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  // Counter register; reset value lets the owner start mid-sequence
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= RST_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  // done marks the edge on which the N-th count since load completes
  assign value = value_q;
  assign done  = (value_q == TW'(1));

endmodule

// File: rtl/clk_mode_ctrl.sv
// rtl/clk_mode_ctrl.sv - divider mode sequencer (optional err port: MODE_CTRL_ERR_EN)
module clk_mode_ctrl
  import clk_mode_pkg::*;
#(
  parameter int NUM_MODES  = 4,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WARM_CYC   = WARM_CYC_DEF,
  localparam int MW        = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  input  logic [MW-1:0]        req_mode,
  output logic                 req_ready,
  output logic [NUM_MODES-1:0] div_en,
  output logic [MW-1:0]        sel,
  output logic                 gate_en,
  output logic [MW-1:0]        mode_cur
`ifdef MODE_CTRL_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int TW = timer_width(SETTLE_CYC, WARM_CYC);

  state_e                 state_q, state_d;
  logic [MW-1:0]          mode_cur_q, mode_cur_d;
  logic [MW-1:0]          sel_q, sel_d;
  logic [MW-1:0]          tgt_q, tgt_d;
  logic [NUM_MODES-1:0]   div_en_q, div_en_d;
  logic                   gate_en_q, gate_en_d;
`ifdef MODE_CTRL_ERR_EN
  logic                   err_q, err_d;
`endif

  logic                   tmr_load;
  logic [TW-1:0]          tmr_load_val;
  logic [TW-1:0]          tmr_value;
  logic                   tmr_done;
  logic                   req_illegal;

  assign req_illegal = (int'(req_mode) >= NUM_MODES);

  clk_mode_timer #(
    .TW      (TW),
    .RST_VAL (TW'(WARM_CYC))
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  // Sequencer: gate off and drain, switch select and enable, warm up, reopen gate
  always_comb begin
    state_d      = state_q;
    mode_cur_d   = mode_cur_q;
    sel_d        = sel_q;
    tgt_d        = tgt_q;
    div_en_d     = div_en_q;
    gate_en_d    = gate_en_q;
`ifdef MODE_CTRL_ERR_EN
    err_d        = err_q;
`endif
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
`ifdef MODE_CTRL_ERR_EN
            err_d = 1'b1;
`endif
          end else if (req_mode != mode_cur_q) begin
            tgt_d        = req_mode;
            gate_en_d    = 1'b0;
            div_en_d     = '0;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(SETTLE_CYC);
            state_d      = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_done) begin
          sel_d        = tgt_q;
          mode_cur_d   = tgt_q;
          div_en_d     = NUM_MODES'(1) << tgt_q;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(WARM_CYC);
          state_d      = ST_WARM;
        end
      end
      ST_WARM: begin
        if (tmr_done) begin
          gate_en_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset restarts warm-up of mode 0 with the gate closed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_WARM;
      mode_cur_q <= '0;
      sel_q      <= '0;
      tgt_q      <= '0;
      div_en_q   <= NUM_MODES'(1);
      gate_en_q  <= 1'b0;
`ifdef MODE_CTRL_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_cur_q <= mode_cur_d;
      sel_q      <= sel_d;
      tgt_q      <= tgt_d;
      div_en_q   <= div_en_d;
      gate_en_q  <= gate_en_d;
`ifdef MODE_CTRL_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  // The timer is always parked at zero whenever the sequencer is idle
  a_idle_timer_zero: assert property (@(posedge clk) disable iff (!rstn)
    (state_q == ST_IDLE) |-> (tmr_value == '0));

  assign req_ready = (state_q == ST_IDLE);
  assign div_en    = div_en_q;
  assign sel       = sel_q;
  assign gate_en   = gate_en_q;
  assign mode_cur  = mode_cur_q;
`ifdef MODE_CTRL_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// tb/tb_clk_mode_ctrl.sv - directed self-checking bench for clk_mode_ctrl
module tb_clk_mode_ctrl;

  logic       clk;
  logic       rstn;

  logic       a_req_valid;
  logic [1:0] a_req_mode;
  logic       a_req_ready;
  logic [3:0] a_div_en;
  logic [1:0] a_sel;
  logic       a_gate_en;
  logic [1:0] a_mode_cur;

  logic       b_req_valid;
  logic [1:0] b_req_mode;
  logic       b_req_ready;
  logic [2:0] b_div_en;
  logic [1:0] b_sel;
  logic       b_gate_en;
  logic [1:0] b_mode_cur;

`ifdef MODE_CTRL_ERR_EN
  logic       a_err;
  logic       b_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clk_mode_ctrl #(.NUM_MODES(4), .SETTLE_CYC(4), .WARM_CYC(8)) u_dut_a (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (a_req_valid),
    .req_mode  (a_req_mode),
    .req_ready (a_req_ready),
    .div_en    (a_div_en),
    .sel       (a_sel),
    .gate_en   (a_gate_en),
    .mode_cur  (a_mode_cur)
`ifdef MODE_CTRL_ERR_EN
    ,
    .err       (a_err)
`endif
  );

  clk_mode_ctrl #(.NUM_MODES(3), .SETTLE_CYC(4), .WARM_CYC(8)) u_dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (b_req_valid),
    .req_mode  (b_req_mode),
    .req_ready (b_req_ready),
    .div_en    (b_div_en),
    .sel       (b_sel),
    .gate_en   (b_gate_en),
    .mode_cur  (b_mode_cur)
`ifdef MODE_CTRL_ERR_EN
    ,
    .err       (b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset at a negedge and confirm the gate opens exactly 8 edges later
  task automatic release_and_warm(input string tag);
    rstn = 1'b1;
    step(7);
    check({tag, "_gate_before"}, a_gate_en, 1'b0);
    check({tag, "_ready_before"}, a_req_ready, 1'b0);
    step(1);
    check({tag, "_gate_open"}, a_gate_en, 1'b1);
    check({tag, "_ready_open"}, a_req_ready, 1'b1);
  endtask

  initial begin
    rstn        = 1'b0;
    a_req_valid = 1'b0;
    a_req_mode  = 2'd0;
    b_req_valid = 1'b0;
    b_req_mode  = 2'd0;
    step(2);

    check("rst_div_en", a_div_en, 4'b0001);
    check("rst_sel", a_sel, 2'd0);
    check("rst_mode_cur", a_mode_cur, 2'd0);
    check("rst_gate", a_gate_en, 1'b0);
    check("rst_ready", a_req_ready, 1'b0);
`ifdef MODE_CTRL_ERR_EN
    check("rst_err", a_err, 1'b0);
`endif

    // Reset release
    release_and_warm("rel");
    check("rel_div_en", a_div_en, 4'b0001);
    check("rel_sel", a_sel, 2'd0);
    check("b_rel_gate", b_gate_en, 1'b1);

    // Illegal request on the 3-mode instance
    b_req_valid = 1'b1;
    b_req_mode  = 2'd3;
    check("ill_ready", b_req_ready, 1'b1);
    step(1);
    b_req_valid = 1'b0;
    check("ill_div_en", b_div_en, 3'b001);
    check("ill_mode_cur", b_mode_cur, 2'd0);
    check("ill_sel", b_sel, 2'd0);
    check("ill_gate", b_gate_en, 1'b1);
    check("ill_ready_after", b_req_ready, 1'b1);
`ifdef MODE_CTRL_ERR_EN
    check("ill_err", b_err, 1'b1);
    step(3);
    check("ill_err_sticky", b_err, 1'b1);
`endif

    // Switch 0 -> 2; a later req_mode change must not matter
    a_req_valid = 1'b1;
    a_req_mode  = 2'd2;
    step(1);
    a_req_valid = 1'b0;
    a_req_mode  = 2'd1;
    check("sw2_drain_div", a_div_en, 4'b0000);
    check("sw2_drain_gate", a_gate_en, 1'b0);
    check("sw2_drain_ready", a_req_ready, 1'b0);
    step(3);
    check("sw2_drain_div_last", a_div_en, 4'b0000);
    check("sw2_drain_sel", a_sel, 2'd0);
    step(1);
    check("sw2_div", a_div_en, 4'b0100);
    check("sw2_sel", a_sel, 2'd2);
    check("sw2_mode_cur", a_mode_cur, 2'd2);
    check("sw2_warm_gate", a_gate_en, 1'b0);
    step(7);
    check("sw2_gate_e11", a_gate_en, 1'b0);
    step(1);
    check("sw2_gate_e12", a_gate_en, 1'b1);
    check("sw2_ready", a_req_ready, 1'b1);

    // Switch 2 -> 1
    a_req_valid = 1'b1;
    a_req_mode  = 2'd1;
    step(1);
    a_req_valid = 1'b0;
    step(11);
    check("sw1_gate_e11", a_gate_en, 1'b0);
    step(1);
    check("sw1_gate_e12", a_gate_en, 1'b1);
    check("sw1_div", a_div_en, 4'b0010);

    // Same-mode request: accepted, nothing moves
    a_req_valid = 1'b1;
    a_req_mode  = 2'd1;
    check("same_ready", a_req_ready, 1'b1);
    step(1);
    a_req_valid = 1'b0;
    check("same_gate", a_gate_en, 1'b1);
    check("same_div", a_div_en, 4'b0010);
    check("same_ready_after", a_req_ready, 1'b1);
    check("same_mode_cur", a_mode_cur, 2'd1);

    // Fresh reset, then back-to-back 0 -> 1 with req 3 held during the switch
    rstn = 1'b0;
    step(2);
    release_and_warm("rel2");
    a_req_valid = 1'b1;
    a_req_mode  = 2'd1;
    step(1);
    a_req_mode  = 2'd3;
    step(4);
    check("b2b_mode_cur_1", a_mode_cur, 2'd1);
    check("b2b_div_1", a_div_en, 4'b0010);
    step(7);
    check("b2b_ignored_ready", a_req_ready, 1'b0);
    check("b2b_ignored_mode", a_mode_cur, 2'd1);
    step(1);
    check("b2b_gate_1", a_gate_en, 1'b1);
    check("b2b_ready_1", a_req_ready, 1'b1);
    step(1);
    a_req_valid = 1'b0;
    check("b2b_second_div", a_div_en, 4'b0000);
    check("b2b_second_gate", a_gate_en, 1'b0);
    step(11);
    check("b2b_gate_e11", a_gate_en, 1'b0);
    step(1);
    check("b2b_final_mode", a_mode_cur, 2'd3);
    check("b2b_final_div", a_div_en, 4'b1000);
    check("b2b_final_gate", a_gate_en, 1'b1);

    // Reset two cycles into a 3 -> 0 switch
    a_req_valid = 1'b1;
    a_req_mode  = 2'd0;
    step(1);
    a_req_valid = 1'b0;
    check("mid_gate_e1", a_gate_en, 1'b0);
    step(1);
    check("mid_gate_e2", a_gate_en, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid_rst_div", a_div_en, 4'b0001);
    check("mid_rst_sel", a_sel, 2'd0);
    check("mid_rst_mode", a_mode_cur, 2'd0);
    check("mid_rst_gate", a_gate_en, 1'b0);
    check("mid_rst_ready", a_req_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("mid_hold_gate", a_gate_en, 1'b0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("mid_warm_gate", a_gate_en, 1'b0);
    end
    step(1);
    check("mid_final_gate", a_gate_en, 1'b1);
    check("mid_final_div", a_div_en, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
